memrw_burst_master: RTL and testbench
=====================================

# memrw_burst_master

Initiator-side engine that drives the word-granular DPI memory port (r_enable/r_index/r_data, w_enable/w_index/w_data/w_mask, enable) of the simulation RAM helper. It accepts burst requests from the simulated SoC fabric and issues one memory access per beat, translating byte addresses to word indices. It also buffers read data under backpressure and rejects out-of-range bursts. It sits between the bus-bridge glue and the memory helper in the difftest/gcpt simulation top.

## Interface
- ADDR_BASE, 64'h8000_0000, byte address mapped to word index 0
- RAM_BYTES, 64'h8000_0000 (2 GiB), memory span; 8 GiB build sets 64'h2_0000_0000
- RFIFO_DEPTH, 4, read-response buffer entries (power of two, ≥3)
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  burst request handshake
- req_write  in  1  1 = write burst
- req_addr  in  64  byte address; bits [2:0] ignored
- req_len  in  8  beats minus one (1..256 beats)
- wdata_valid / wdata_ready  in / out  1  write-beat handshake
- wdata, wmask  in  64 each  write data, per-bit mask
- rdata_valid / rdata_ready  out / in  1  read-beat handshake
- rdata  out  64  read data
- rdata_last, rdata_err  out  1 each  last beat of burst; burst was out of range
- write_done, write_err  out  1 each  one-cycle pulse at burst completion; error flag
- r_enable, r_index  out  1, 64  memory read strobe, word index
- r_data  in  64  memory read data, valid the cycle after r_enable
- w_enable, w_index, w_data, w_mask  out  1, 64, 64, 64  memory write strobe, index, data, mask
- enable  out  1  equals r_enable | w_enable

## Operation
- States: IDLE, READ, WRITE. req_ready = (state == IDLE). No other request is accepted while a burst is in progress.
- Acceptance: base_idx = (req_addr - ADDR_BASE) >> 3. The burst is in range iff req_addr ≥ ADDR_BASE and req_addr - ADDR_BASE + 8*(req_len+1) ≤ RAM_BYTES, computed in 65 bits.
- Beat counter beat[8:0] counts from 0 to req_len. The index for a beat is base_idx + beat, 64-bit zero-extended.
- READ: a beat is issued when fifo_count + rd_pending < RFIFO_DEPTH. rd_pending is r_enable delayed by one cycle. r_data is pushed into the FIFO when rd_pending is high. Each FIFO entry carries {data, last, err}. The state returns to IDLE after the last beat is issued; buffered responses keep draining afterward.
- Read error: r_enable is never raised. req_len+1 beats of zero data are pushed with err=1, subject to the same space rule.
- WRITE: wdata_ready = (state == WRITE). Each handshake registers w_enable, w_index, w_data, w_mask for exactly one cycle. After the last handshake the state returns to IDLE. write_done pulses together with the last w_enable.
- Write error: beats are consumed but w_enable stays 0. write_done and write_err pulse one cycle after the last handshake.
- A read accepted while earlier responses are still in the FIFO returns in order, after those responses.

## Timing
- All memory-side outputs are registered.
- Read, FIFO not full: request accepted at edge T, r_enable high in T+1, r_data valid in T+2, pushed at end of T+2, rdata_valid in T+3. Sustained throughput is one beat per cycle with RFIFO_DEPTH ≥ 3.
- Write: handshake in cycle t, w_enable high in t+1.
- rdata_valid stays high and rdata stays stable until rdata_ready. Pop and push in the same cycle are allowed when the FIFO is full.
- Reset (asynchronous, any time): state goes to IDLE and the FIFO and counters clear. Every output resets to 0, except req_ready, which is 1 after reset release. An interrupted burst is abandoned and no partial response is emitted.

## Structure
- Package memrw_pkg contains: the state enum, WORD_BYTES = 8, WORD_SHIFT = 3, and the response-entry struct {data, last, err}.
- Sub-module memrw_resp_fifo: show-ahead synchronous FIFO with count output, parameterized by depth and entry type.

## Test plan
- RAM word 0 preloaded with 64'hDEAD_BEEF_0123_4567; single read at 0x8000_0000 → r_index=0 in T+1; rdata=preload with last=1 and err=0 in T+3.
- 8-beat read at 0x8000_0040 with rdata_ready low for cycles 3–10 → r_index runs 8..15 in order; no more than RFIFO_DEPTH beats are outstanding; all 8 beats arrive unduplicated and only the 8th has last=1.
- 4-beat write at 0x8000_1000 with wmask=64'h0000_0000_FFFF_FFFF over a preload of all ones, then read back → upper 32 bits of every word read back as ones; write_done pulses once, with the 4th w_enable.
- Read at 0x7FFF_FFF8, and a 2-beat read at ADDR_BASE+RAM_BYTES-8 → no r_enable; zero data with err=1 for each beat. A write to the same addresses → no w_enable and write_err pulses.
- Reset asserted during beat 3 of an 8-beat read → all outputs 0 immediately; req_ready=1 after release; the next single read returns correct data.
- Read with req_len=255 at 0x8000_0000 → 256 beats, r_index 0..255, and the beat counter does not wrap early.

Source files
------------

// File: rtl/memrw_pkg.sv
// memrw_pkg: shared types and helpers for the burst master.
//   state_e  - burst engine state
//   resp_t   - read-response buffer entry {data, last, err}
//   burst_in_range - range check of a burst against the RAM window
package memrw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int WORD_BYTES = 8;
  localparam int WORD_SHIFT = 3;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } resp_t;

  // Evaluated in 65 bits so a burst ending exactly at 2^64 cannot wrap
  // back into range.
  function automatic logic burst_in_range(input logic [63:0] addr,
                                          input logic [7:0]  len,
                                          input logic [63:0] base,
                                          input logic [63:0] span);
    logic [64:0] off;
    logic [64:0] fin;
    off = {1'b0, addr} - {1'b0, base};
    fin = off + (({57'd0, len} + 65'd1) << WORD_SHIFT);
    return (addr >= base) && (fin <= {1'b0, span});
  endfunction

endpackage

// File: rtl/memrw_burst_master_if.sv
// memrw_burst_master_if: fabric-side burst request / write-beat / read-beat
// handshakes plus the word-granular memory port of the RAM helper.
//   master modport - the burst engine view
//   slave  modport - the fabric + memory environment view
interface memrw_burst_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [63:0] wdata;
  logic [63:0] wmask;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [63:0] rdata;
  logic        rdata_last;
  logic        rdata_err;
  logic        write_done;
  logic        write_err;
  logic        r_enable;
  logic [63:0] r_index;
  logic [63:0] r_data;
  logic        w_enable;
  logic [63:0] w_index;
  logic [63:0] w_data;
  logic [63:0] w_mask;
  logic        enable;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata, wmask, rdata_ready, r_data,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, rdata_err,
    output write_done, write_err,
    output r_enable, r_index, w_enable, w_index, w_data, w_mask, enable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata, wmask, rdata_ready, r_data,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, rdata_err,
    input  write_done, write_err,
    input  r_enable, r_index, w_enable, w_index, w_data, w_mask, enable
  );
endinterface

// File: rtl/memrw_resp_fifo.sv
// memrw_resp_fifo: show-ahead synchronous FIFO with occupancy output.
//   i_clk, i_rst_n    - clock, asynchronous active-low reset (control only)
//   i_push, i_data    - write side; ignored when full unless popping too
//   i_pop             - read side; ignored when empty
//   o_data            - head entry (valid while o_count != 0)
//   o_count           - number of stored entries
module memrw_resp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/memrw_burst_master.sv
// memrw_burst_master: burst initiator for the word-granular RAM helper port.
// Accepts one read or write burst at a time, issues one memory access per
// beat (byte address -> word index relative to ADDR_BASE), buffers read data
// in a response FIFO and answers out-of-range bursts with error beats.
//   i_clock, i_reset_n - clock, asynchronous active-low reset
//   bus (master)       - request / write-beat / read-beat handshakes,
//                        write completion pulses and the memory port
module memrw_burst_master
  import memrw_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
  parameter logic [63:0] RAM_BYTES   = 64'h8000_0000,
  parameter int          RFIFO_DEPTH = 4
) (
  input logic                  i_clock,
  input logic                  i_reset_n,
  memrw_burst_master_if.master bus
);
  localparam int CW = $clog2(RFIFO_DEPTH) + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_out_en;
  logic [8:0]    r_beat;
  logic [7:0]    r_len;
  logic [63:0]   r_base;
  logic          r_err;
  logic          r_rd_en;
  logic [63:0]   r_rd_idx;
  logic          r_iss_p0;
  logic          r_iss_last_p0;
  logic          r_iss_err_p0;
  logic          r_pend_p1;
  logic          r_pend_last_p1;
  logic          r_pend_err_p1;
  logic          r_wr_en;
  logic [63:0]   r_wr_idx;
  logic [63:0]   r_wr_data;
  logic [63:0]   r_wr_mask;
  logic          r_wdone;
  logic          r_werr;

  logic          w_accept;
  logic          w_in_range;
  logic [63:0]   w_base_idx;
  logic          w_last_beat;
  logic [CW:0]   w_inflight;
  logic          w_space;
  logic          w_rd_issue;
  logic          w_wr_hs;
  logic [63:0]   w_beat_idx;
  logic [CW-1:0] w_fcount;
  logic          w_rvalid;
  logic          w_pop;
  resp_t         w_push_entry;
  resp_t         w_head;

  assign bus.req_ready   = (r_state == ST_IDLE) && r_out_en;
  assign bus.wdata_ready = (r_state == ST_WRITE);
  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_in_range  = burst_in_range(bus.req_addr, bus.req_len, ADDR_BASE, RAM_BYTES);
  assign w_base_idx  = (bus.req_addr - ADDR_BASE) >> WORD_SHIFT;
  assign w_last_beat = (r_beat == {1'b0, r_len});
  assign w_beat_idx  = r_base + {55'd0, r_beat};

  // Everything already issued but not yet in the FIFO counts against the
  // space: the beat strobed this cycle and the one whose data lands next.
  assign w_inflight = {1'b0, w_fcount} + {{CW{1'b0}}, r_iss_p0} + {{CW{1'b0}}, r_pend_p1};
  assign w_space    = w_inflight < (CW+1)'(RFIFO_DEPTH);
  assign w_rd_issue = (r_state == ST_READ) && w_space;
  assign w_wr_hs    = (r_state == ST_WRITE) && bus.wdata_valid;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = bus.req_write ? ST_WRITE : ST_READ;
      ST_READ:  if (w_rd_issue && w_last_beat) w_state_nxt = ST_IDLE;
      ST_WRITE: if (w_wr_hs && w_last_beat) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out_en <= 1'b1;
    end
  end

  // Stage p0: burst bookkeeping and beat issue onto the memory port
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_beat        <= '0;
      r_len         <= '0;
      r_base        <= '0;
      r_err         <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_idx      <= '0;
      r_iss_p0      <= 1'b0;
      r_iss_last_p0 <= 1'b0;
      r_iss_err_p0  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_idx      <= '0;
      r_wr_data     <= '0;
      r_wr_mask     <= '0;
      r_wdone       <= 1'b0;
      r_werr        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_beat <= '0;
        r_len  <= bus.req_len;
        r_base <= w_base_idx;
        r_err  <= !w_in_range;
      end else if (w_rd_issue || w_wr_hs) begin
        r_beat <= r_beat + 9'd1;
      end

      // Error beats travel the same pipeline so they obey the same space
      // rule and keep ordering, but never strobe the memory.
      r_iss_p0      <= w_rd_issue;
      r_iss_last_p0 <= w_last_beat;
      r_iss_err_p0  <= r_err;
      r_rd_en       <= w_rd_issue && !r_err;
      if (w_rd_issue && !r_err) r_rd_idx <= w_beat_idx;

      r_wr_en <= w_wr_hs && !r_err;
      if (w_wr_hs && !r_err) begin
        r_wr_idx  <= w_beat_idx;
        r_wr_data <= bus.wdata;
        r_wr_mask <= bus.wmask;
      end
      r_wdone <= w_wr_hs && w_last_beat;
      r_werr  <= w_wr_hs && w_last_beat && r_err;
    end
  end

  // Stage p1: memory data returns; pushed into the response FIFO next edge
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend_p1      <= 1'b0;
      r_pend_last_p1 <= 1'b0;
      r_pend_err_p1  <= 1'b0;
    end else begin
      r_pend_p1      <= r_iss_p0;
      r_pend_last_p1 <= r_iss_last_p0;
      r_pend_err_p1  <= r_iss_err_p0;
    end
  end

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = r_pend_err_p1 ? 64'd0 : bus.r_data;
    w_push_entry.last = r_pend_last_p1;
    w_push_entry.err  = r_pend_err_p1;
  end

  memrw_resp_fifo #(
    .DEPTH (RFIFO_DEPTH),
    .T     (resp_t)
  ) u_rfifo (
    .i_clk   (i_clock),
    .i_rst_n (i_reset_n),
    .i_push  (r_pend_p1),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fcount)
  );

  assign w_rvalid = (w_fcount != '0);
  assign w_pop    = w_rvalid && bus.rdata_ready;

  // Head storage is not reset, so the response fields are gated by valid.
  assign bus.rdata_valid = w_rvalid;
  assign bus.rdata       = w_rvalid ? w_head.data : 64'd0;
  assign bus.rdata_last  = w_rvalid && w_head.last;
  assign bus.rdata_err   = w_rvalid && w_head.err;

  assign bus.write_done = r_wdone;
  assign bus.write_err  = r_werr;
  assign bus.r_enable   = r_rd_en;
  assign bus.r_index    = r_rd_idx;
  assign bus.w_enable   = r_wr_en;
  assign bus.w_index    = r_wr_idx;
  assign bus.w_data     = r_wr_data;
  assign bus.w_mask     = r_wr_mask;
  assign bus.enable     = r_rd_en | r_wr_en;
endmodule

// File: tb/tb_memrw_burst_master.sv
module tb_memrw_burst_master;
  import memrw_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] SPAN  = 64'h8000_0000;
  localparam int          DEPTH = 4;
  localparam logic [63:0] MASK_LO = 64'h0000_0000_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memrw_burst_master_if bus();

  memrw_burst_master #(
    .ADDR_BASE   (BASE),
    .RAM_BYTES   (SPAN),
    .RFIFO_DEPTH (DEPTH)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [63:0] idx;
    logic [63:0] data;
    logic [63:0] mask;
    logic        last;
  } wexp_t;

  resp_t       q_resp[$];
  logic [63:0] q_ridx[$];
  wexp_t       q_w[$];
  logic        q_ws[$];

  int n_pass  = 0;
  int n_total = 0;
  int n_ren   = 0;
  int n_pop   = 0;
  int n_wdone = 0;
  int max_out = 0;

  logic [63:0] mem [1024];

  function automatic logic [63:0] pat(input int i);
    return {32'hCAFE_0000 + 32'(i), 32'h0000_F000 + 32'(i)};
  endfunction

  // RAM preload image: word 0 is a signature, words 0x200..0x203 all ones.
  function automatic logic [63:0] init_word(input int i);
    if (i == 0) return 64'hDEAD_BEEF_0123_4567;
    if (i >= 'h200 && i <= 'h203) return '1;
    return pat(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_total++;
    $display("FAIL %s: actual unexpected/timeout required none", name);
  endtask

  // RAM helper model: registered read, masked write.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      bus.r_data <= '0;
    end else begin
      if (bus.r_enable) bus.r_data <= mem[bus.r_index[9:0]];
      if (bus.w_enable)
        mem[bus.w_index[9:0]] <= (mem[bus.w_index[9:0]] & ~bus.w_mask) | (bus.w_data & bus.w_mask);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.r_enable) begin
        n_ren++;
        chk("enable_on_read", bus.enable, 64'd1);
        if (q_ridx.size() == 0) fail_evt("r_enable");
        else chk("r_index", bus.r_index, q_ridx.pop_front());
      end
      if (n_ren - n_pop > max_out) max_out = n_ren - n_pop;
      if (bus.w_enable) begin
        chk("enable_on_write", bus.enable, 64'd1);
        if (q_w.size() == 0) fail_evt("w_enable");
        else begin
          wexp_t e;
          e = q_w.pop_front();
          chk("w_index", bus.w_index, e.idx);
          chk("w_data", bus.w_data, e.data);
          chk("w_mask", bus.w_mask, e.mask);
          chk("write_done_with_w_enable", 64'(bus.write_done), 64'(e.last));
        end
      end
      if (bus.write_done) begin
        n_wdone++;
        if (q_ws.size() == 0) fail_evt("write_done");
        else chk("write_err", 64'(bus.write_err), 64'(q_ws.pop_front()));
      end
      if (bus.rdata_valid && bus.rdata_ready) begin
        n_pop++;
        if (q_resp.size() == 0) fail_evt("rdata_valid");
        else begin
          resp_t r;
          r = q_resp.pop_front();
          chk("rdata", bus.rdata, r.data);
          chk("rdata_last", 64'(bus.rdata_last), 64'(r.last));
          chk("rdata_err", 64'(bus.rdata_err), 64'(r.err));
        end
      end
    end
  end

  task automatic exp_read(input int idx, input int n, input logic err);
    for (int b = 0; b < n; b++) begin
      resp_t r;
      if (!err) q_ridx.push_back(64'(idx + b));
      r.data = err ? 64'd0 : init_word(idx + b);
      r.last = (b == n - 1);
      r.err  = err;
      q_resp.push_back(r);
    end
  endtask

  task automatic send_req(input logic wr, input logic [63:0] addr, input logic [7:0] len);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        return;
      end
    end
    bus.req_valid = 1'b0;
    fail_evt("req_accept_timeout");
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [63:0] m);
    bus.wdata_valid = 1'b1;
    bus.wdata = d;
    bus.wmask = m;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wdata_ready) begin
        @(posedge clk); #1;
        bus.wdata_valid = 1'b0;
        return;
      end
    end
    bus.wdata_valid = 1'b0;
    fail_evt("wdata_accept_timeout");
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q_resp.size() == 0 && q_ridx.size() == 0 && q_w.size() == 0 &&
          q_ws.size() == 0 && !bus.rdata_valid && bus.req_ready) break;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("pending_expectations", 64'(q_resp.size() + q_ridx.size() + q_w.size() + q_ws.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_wdata_ready"}, 64'(bus.wdata_ready), 64'd0);
    chk({tag, "_rdata_valid"}, 64'(bus.rdata_valid), 64'd0);
    chk({tag, "_rdata"}, bus.rdata, 64'd0);
    chk({tag, "_rdata_last"}, 64'(bus.rdata_last), 64'd0);
    chk({tag, "_rdata_err"}, 64'(bus.rdata_err), 64'd0);
    chk({tag, "_write_done"}, 64'(bus.write_done), 64'd0);
    chk({tag, "_write_err"}, 64'(bus.write_err), 64'd0);
    chk({tag, "_r_enable"}, 64'(bus.r_enable), 64'd0);
    chk({tag, "_r_index"}, bus.r_index, 64'd0);
    chk({tag, "_w_enable"}, 64'(bus.w_enable), 64'd0);
    chk({tag, "_w_index"}, bus.w_index, 64'd0);
    chk({tag, "_w_data"}, bus.w_data, 64'd0);
    chk({tag, "_w_mask"}, bus.w_mask, 64'd0);
    chk({tag, "_enable"}, 64'(bus.enable), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int r0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.wmask       = '0;
    bus.rdata_ready = 1'b1;

    // Reset state
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_reset", 64'(bus.req_ready), 64'd1);

    // Single read of the signature word, exact latency
    exp_read(0, 1, 1'b0);
    send_req(1'b0, BASE, 8'd0);
    @(posedge clk); #1;
    chk("lat_r_enable_T1", 64'(bus.r_enable), 64'd1);
    chk("lat_r_index_T1", bus.r_index, 64'd0);
    @(posedge clk); #1;
    chk("lat_rdata_valid_T2", 64'(bus.rdata_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_rdata_valid_T3", 64'(bus.rdata_valid), 64'd1);
    chk("lat_rdata_T3", bus.rdata, 64'hDEAD_BEEF_0123_4567);
    chk("lat_rdata_last_T3", 64'(bus.rdata_last), 64'd1);
    wait_drain(50);

    // 8-beat read with backpressure in cycles T+3..T+10
    n_ren = 0; n_pop = 0; max_out = 0;
    exp_read(8, 8, 1'b0);
    send_req(1'b0, BASE + 64'h40, 8'd7);
    repeat (3) @(posedge clk);
    #1 bus.rdata_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("stall_rdata_valid", 64'(bus.rdata_valid), 64'd1);
    chk("stall_rdata_hold", bus.rdata, pat(8));
    chk("stall_no_issue", 64'(bus.r_enable), 64'd0);
    @(posedge clk);
    #1 bus.rdata_ready = 1'b1;
    wait_drain(100);
    chk("max_outstanding", 64'(max_out), 64'(DEPTH));
    chk("burst8_beats", 64'(n_ren), 64'd8);

    // 4-beat masked write over all-ones, then read back
    w0 = n_wdone;
    for (int b = 0; b < 4; b++) begin
      wexp_t e;
      e.idx  = 64'h200 + 64'(b);
      e.data = {32'h5555_5555, 32'hC0DE_0000 + 32'(b)};
      e.mask = MASK_LO;
      e.last = (b == 3);
      q_w.push_back(e);
    end
    q_ws.push_back(1'b0);
    send_req(1'b1, BASE + 64'h1000, 8'd3);
    for (int b = 0; b < 4; b++) send_beat({32'h5555_5555, 32'hC0DE_0000 + 32'(b)}, MASK_LO);
    wait_drain(50);
    chk("write_done_count", 64'(n_wdone - w0), 64'd1);
    for (int b = 0; b < 4; b++) begin
      resp_t r;
      q_ridx.push_back(64'h200 + 64'(b));
      r.data = {32'hFFFF_FFFF, 32'hC0DE_0000 + 32'(b)};
      r.last = (b == 3);
      r.err  = 1'b0;
      q_resp.push_back(r);
    end
    send_req(1'b0, BASE + 64'h1000, 8'd3);
    wait_drain(50);

    // Range boundaries: below base, past end, and the last valid word
    r0 = n_ren;
    exp_read(0, 1, 1'b1);
    send_req(1'b0, 64'h7FFF_FFF8, 8'd0);
    exp_read(0, 2, 1'b1);
    send_req(1'b0, BASE + SPAN - 64'd8, 8'd1);
    wait_drain(50);
    chk("err_read_no_r_enable", 64'(n_ren - r0), 64'd0);
    q_ridx.push_back(64'h0FFF_FFFF);
    begin
      resp_t r;
      r.data = pat(1023);
      r.last = 1'b1;
      r.err  = 1'b0;
      q_resp.push_back(r);
    end
    send_req(1'b0, BASE + SPAN - 64'd8, 8'd0);
    wait_drain(50);
    w0 = n_wdone;
    q_ws.push_back(1'b1);
    send_req(1'b1, 64'h7FFF_FFF8, 8'd0);
    send_beat(64'h1234, '1);
    q_ws.push_back(1'b1);
    send_req(1'b1, BASE + SPAN - 64'd8, 8'd1);
    send_beat(64'h5678, '1);
    send_beat(64'h9ABC, '1);
    wait_drain(50);
    chk("err_write_done_count", 64'(n_wdone - w0), 64'd2);

    // Reset in the middle of an 8-beat read
    bus.rdata_ready = 1'b0;
    r0 = n_ren;
    exp_read(0, 8, 1'b0);
    send_req(1'b0, BASE, 8'd7);
    for (int i = 0; i < 50 && (n_ren - r0) < 3; i++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    q_resp.delete(); q_ridx.delete(); q_w.delete(); q_ws.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.rdata_ready = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_midreset", 64'(bus.req_ready), 64'd1);
    repeat (3) @(posedge clk); #1;
    chk("no_partial_response", 64'(bus.rdata_valid), 64'd0);
    exp_read(1, 1, 1'b0);
    send_req(1'b0, BASE + 64'd8, 8'd0);
    wait_drain(50);

    // Maximum burst: 256 beats
    r0 = n_ren;
    exp_read(0, 256, 1'b0);
    send_req(1'b0, BASE, 8'd255);
    wait_drain(2000);
    chk("burst256_beats", 64'(n_ren - r0), 64'd256);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
